bin_to_bcd_sequencer: RTL and testbench

Sequential binary-to-BCD converter that feeds the six per-digit 7-segment decoders driving HEX0–HEX5 on the DE10-Lite. It accepts an unsigned binary value on a start pulse and runs a shift-and-add-3 (double-dabble) algorithm one bit per clock. It presents six registered BCD nibbles, each wired directly to one segment decoder's 4-bit digit input. Outputs hold between conversions, so the display never shows intermediate values.

---
 rtl/bin_to_bcd_sequencer.sv | 113 +++++++++++
 tb/tb_bin_to_bcd_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_sequencer
// Description : Sequential binary-to-BCD converter (shift-and-add-3, one bit
//               per clock) producing six registered BCD digits for HEX0..HEX5.
//               Optional macro BCD_OVERFLOW_SAT_EN saturates bcd_out to
//               24'h999999 when the value exceeds 999999.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_sequencer #(
    parameter int BIN_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 busy,
    output logic                 done,
    output logic [23:0]          bcd_out,
    output logic                 overflow
);

    localparam int                 c_CNT_W    = $clog2(BIN_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BIN_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [BIN_WIDTH-1:0]   r_shift;
    logic [31:0]            r_scratch;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_busy;
    logic                   r_done;
    logic [23:0]            r_bcd;
    logic                   r_overflow;

    logic [27:0]            w_adj;
    logic                   w_ovf_next;
    logic [23:0]            w_bcd_next;

    // The top digit never exceeds 1 for inputs below 2^24, so it needs no
    // add-3 correction; only the low seven digits are adjusted.
    for (genvar gi = 0; gi < 7; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                ? (r_scratch[4*gi +: 4] + 4'd3)
                                : r_scratch[4*gi +: 4];
    end

    assign w_ovf_next = |r_scratch[31:24];

`ifdef BCD_OVERFLOW_SAT_EN
    assign w_bcd_next = w_ovf_next ? 24'h999999 : r_scratch[23:0];
`else
    assign w_bcd_next = r_scratch[23:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= 24'h000000;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift   <= bin_in;
                        r_scratch <= '0;
                        r_count   <= c_CNT_LOAD;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= {r_scratch[30:28], w_adj, r_shift[BIN_WIDTH-1]};
                    r_shift   <= {r_shift[BIN_WIDTH-2:0], 1'b0};
                    r_count   <= r_count - c_CNT_ONE;
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd      <= w_bcd_next;
                    r_overflow <= w_ovf_next;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_sequencer.sv
`default_nettype none
// Testbench for bin_to_bcd_sequencer: randomized conversions with a queue
// scoreboard, plus a short directed run on an 8-bit instance.
module tb_bin_to_bcd_sequencer;

    localparam int BW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] bin_in;
    logic          busy, done, overflow;
    logic [23:0]   bcd_out;

    logic          start8;
    logic [7:0]    bin8;
    logic          busy8, done8, overflow8;
    logic [23:0]   bcd8;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [23:0] last_bcd = 24'h0;
    logic        last_ovf = 1'b0;

    bin_to_bcd_sequencer #(.BIN_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    bin_to_bcd_sequencer #(.BIN_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(overflow8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Decimal digits computed arithmetically, low six digits only.
    function automatic logic [23:0] to_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        r = '0;
        x = v % 1000000;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input int unsigned v, input int acc);
        exp_t e;
        e.ovf = (v > 999999);
`ifdef BCD_OVERFLOW_SAT_EN
        e.bcd = e.ovf ? 24'h999999 : to_bcd(v);
`else
        e.bcd = to_bcd(v);
`endif
        e.acc = acc;
        return e;
    endfunction

    // Monitor: samples 1 time unit after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_bcd", 32'(bcd_out), 32'd0);
                chk("rst_ovf", 32'(overflow), 32'd0);
                q.delete();
                last_bcd = 24'h0;
                last_ovf = 1'b0;
            end else begin
                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                        chk("overflow", 32'(overflow), 32'(e.ovf));
                        chk("latency", 32'(cyc - e.acc), 32'(BW + 1));
                        last_bcd = e.bcd;
                        last_ovf = e.ovf;
                    end
                end else begin
                    chk("bcd_hold", 32'(bcd_out), 32'(last_bcd));
                    chk("ovf_hold", 32'(overflow), 32'(last_ovf));
                end
                chk("busy", 32'(busy), 32'(q.size() != 0));
            end
        end
    end

    // Waits (at negedges) until the converter is idle, pulsing junk starts meanwhile.
    task automatic wait_idle(input bit junk);
        int n;
        n = 0;
        while (busy && n < 100) begin
            start  = junk ? ($urandom_range(0, 3) == 0) : 1'b0;
            bin_in = BW'($urandom);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 100) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input int unsigned v, input bit junk);
        wait_idle(junk);
        q.push_back(model(v, cyc + 1));
        start  = 1'b1;
        bin_in = BW'(v);
        @(negedge clk);
        start  = 1'b0;
        bin_in = BW'($urandom);
    endtask

    task automatic run8(input int unsigned v);
        int n;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'(v);
        @(negedge clk);
        start8 = 1'b0;
        bin8   = 8'($urandom);
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("w8_latency", 32'(n), 32'd9);
        chk("w8_bcd", 32'(bcd8), 32'(to_bcd(v)));
        chk("w8_ovf", 32'(overflow8), 32'd0);
    endtask

    initial begin
        int unsigned v;
        rst = 1'b1; start = 1'b0; bin_in = '0; start8 = 1'b0; bin8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 1'b0);
        issue(123456, 1'b0);
        issue(999999, 1'b0);
        issue(1048575, 1'b0);
        issue(42, 1'b1);
        issue(7, 1'b0);

        // Reset ten cycles into a conversion aborts it.
        issue(654321, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);

        // Reset and start on the same edge: reset wins.
        rst = 1'b1; start = 1'b1; bin_in = BW'(555);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 1048575);
                1: v = $urandom_range(0, 999);
                2: v = $urandom_range(999990, 1000009);
                default: v = 1048575 - $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                wait_idle(1'b1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            issue(v, $urandom_range(0, 1) == 1);
        end
        wait_idle(1'b0);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);

        run8(255);
        run8(0);
        run8(99);
        run8(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL global_timeout: actual=running required=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
